matrix_frame_ctrl: RTL and testbench

MATRIX_FRAME_CTRL -- requirements
Module: matrix_frame_ctrl

---
 rtl/matrix_frame_ctrl_if.sv | 23 ++
 rtl/matrix_frame_ctrl.sv | 107 ++++++++++
 tb/tb_matrix_frame_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/matrix_frame_ctrl_if.sv
// Bus between the two row writers / matrix driver and the frame controller.
interface matrix_frame_ctrl_if;
  logic [1:0]  req;
  logic [2:0]  row0;
  logic [2:0]  row1;
  logic [7:0]  data0;
  logic [7:0]  data1;
  logic [1:0]  gnt;
  logic        commit;
  logic        frame_done;
  logic [63:0] matdata;
  logic        swap_pending;

  modport master (
    output req, row0, row1, data0, data1, commit, frame_done,
    input  gnt, matdata, swap_pending
  );

  modport slave (
    input  req, row0, row1, data0, data1, commit, frame_done,
    output gnt, matdata, swap_pending
  );
endinterface

// File: rtl/matrix_frame_ctrl.sv
// Double-buffered 8x8 matrix frame controller: two requesters arbitrate for
// the back buffer, and a committed frame is copied to the front buffer at the
// driver's next end-of-frame pulse.
module matrix_frame_ctrl #(
  parameter int unsigned HOLD_MAX = 8
) (
  input logic              clk,
  input logic              nrst,
  matrix_frame_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e      state_q;
  logic        last_q;
  logic [7:0]  cnt_q;
  logic [63:0] back_q, back_d;
  logic [63:0] front_q;
  logic        pend_q;

  logic        own_sel;
  logic        other_req;
  logic        beat;
  logic [8:0]  cnt_inc;
  logic        hold_hit;
  logic        swap;

  // owner index and the waiting requester's line
  assign own_sel   = (state_q == OWN1);
  assign other_req = bus.req[~own_sel];
  assign beat      = (state_q != IDLE) && bus.req[own_sel];
  assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
  assign hold_hit  = (cnt_inc >= 9'(HOLD_MAX));
  assign swap      = bus.frame_done && (pend_q || bus.commit);

  assign bus.gnt          = {state_q == OWN1, state_q == OWN0};
  assign bus.matdata      = front_q;
  assign bus.swap_pending = pend_q;

  // arbiter: IDLE/OWN0/OWN1 with round-robin tie break and hold limit
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req == 2'b11) begin
            // last_q==1 means requester 1 was served last, so 0 wins
            state_q <= last_q ? OWN0 : OWN1;
            last_q  <= ~last_q;
            cnt_q   <= '0;
          end else if (bus.req[0]) begin
            state_q <= OWN0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (bus.req[1]) begin
            state_q <= OWN1;
            last_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        OWN0, OWN1: begin
          if (!beat || (hold_hit && other_req)) begin
            if (other_req) begin
              state_q <= own_sel ? OWN0 : OWN1;
              last_q  <= ~own_sel;
              cnt_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else if (hold_hit) begin
            // nobody waiting: keep the grant, pin the counter at the limit
            cnt_q <= 8'(HOLD_MAX);
          end else begin
            cnt_q <= cnt_inc[7:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // row write into the back buffer on a granted beat
  always_comb begin
    back_d = back_q;
    if (beat) begin
      if (own_sel) back_d[{bus.row1, 3'b000} +: 8] = bus.data1;
      else         back_d[{bus.row0, 3'b000} +: 8] = bus.data0;
    end
  end

  // buffers and swap request; front takes the pre-write back value
  always_ff @(posedge clk) begin
    if (!nrst) begin
      back_q  <= '0;
      front_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      back_q <= back_d;
      if (swap) front_q <= back_q;
      pend_q <= swap ? 1'b0 : (pend_q || bus.commit);
    end
  end

endmodule

// File: tb/tb_matrix_frame_ctrl.sv
// Bench for matrix_frame_ctrl: directed scenarios then random traffic, all
// checked against a behavioural model of owner/buffers kept here.
module tb_matrix_frame_ctrl;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  matrix_frame_ctrl_if bus();

  matrix_frame_ctrl #(.HOLD_MAX(HOLD)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: owner -1 = nobody, arrays of row bytes
  int         own;
  int         beats;
  int         lastp;
  bit         mpend;
  logic [7:0] mback [8];
  logic [7:0] mfront[8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mpack();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = mfront[i];
    return v;
  endfunction

  function automatic logic [1:0] mgnt();
    if (own < 0) return 2'b00;
    return (own == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic enter(input int n);
    own   = n;
    beats = 0;
    lastp = n;
  endtask

  task automatic model_edge(input logic rn, input logic [1:0] rq, input logic [2:0] r0,
                            input logic [2:0] r1, input logic [7:0] d0, input logic [7:0] d1,
                            input logic cm, input logic fd);
    int other;
    if (!rn) begin
      own = -1; beats = 0; lastp = 1; mpend = 0;
      for (int i = 0; i < 8; i++) begin mback[i] = 8'h00; mfront[i] = 8'h00; end
      return;
    end
    if (fd && (mpend || cm)) begin
      mfront = mback;
      mpend  = 0;
    end else if (cm) begin
      mpend = 1;
    end
    if (own >= 0 && rq[own]) begin
      if (own == 0) mback[r0] = d0;
      else          mback[r1] = d1;
    end
    if (own < 0) begin
      if (rq == 2'b11)  enter(1 - lastp);
      else if (rq[0])   enter(0);
      else if (rq[1])   enter(1);
    end else begin
      other = 1 - own;
      if (!rq[own]) begin
        if (rq[other]) enter(other);
        else own = -1;
      end else begin
        beats++;
        if (beats >= HOLD) begin
          if (rq[other]) enter(other);
          else beats = HOLD;
        end
      end
    end
  endtask

  // one clock: drive, advance the model, check every output
  task automatic cyc(input logic rn, input logic [1:0] rq, input logic [2:0] r0,
                     input logic [2:0] r1, input logic [7:0] d0, input logic [7:0] d1,
                     input logic cm, input logic fd);
    logic [63:0] prev;
    logic        allowed;
    nrst = rn; bus.req = rq; bus.row0 = r0; bus.row1 = r1;
    bus.data0 = d0; bus.data1 = d1; bus.commit = cm; bus.frame_done = fd;
    prev    = bus.matdata;
    allowed = !rn || (fd && (mpend || cm));
    model_edge(rn, rq, r0, r1, d0, d1, cm, fd);
    @(posedge clk);
    #1;
    chk("gnt", {62'd0, bus.gnt}, {62'd0, mgnt()});
    chk("matdata", bus.matdata, mpack());
    chk("swap_pending", {63'd0, bus.swap_pending}, {63'd0, mpend});
    chk("gnt_excl", {63'd0, bus.gnt == 2'b11}, 64'd0);
    chk("mat_hold", {63'd0, (bus.matdata !== prev) && !allowed}, 64'd0);
  endtask

  initial begin
    nrst = 1'b0; bus.req = 2'b00; bus.row0 = '0; bus.row1 = '0;
    bus.data0 = '0; bus.data1 = '0; bus.commit = 1'b0; bus.frame_done = 1'b0;
    own = -1; beats = 0; lastp = 1; mpend = 0;
    for (int i = 0; i < 8; i++) begin mback[i] = 8'h00; mfront[i] = 8'h00; end

    // reset state
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("rst_gnt", {62'd0, bus.gnt}, 64'd0);
    chk("rst_mat", bus.matdata, 64'd0);

    // single writer, commit, frame_done
    cyc(1, 2'b01, 3, 0, 8'hA5, 0, 0, 0);
    chk("single_gnt", {62'd0, bus.gnt}, 64'd1);
    cyc(1, 2'b01, 3, 0, 8'hA5, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 1, 0);
    chk("single_pend", {63'd0, bus.swap_pending}, 64'd1);
    cyc(1, 2'b00, 0, 0, 0, 0, 0, 1);
    chk("single_mat", bus.matdata, 64'hA5 << 24);
    chk("single_pend_clr", {63'd0, bus.swap_pending}, 64'd0);

    // tie after reset, requester 0 first, rotation after HOLD beats
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc(1, 2'b11, 0, 7, 8'h10, 8'h70, 0, 0);
    chk("tie_first", {62'd0, bus.gnt}, 64'd1);
    for (int i = 0; i < HOLD - 1; i++) cyc(1, 2'b11, 3'(i), 7, 8'(i), 8'h70, 0, 0);
    chk("tie_hold", {62'd0, bus.gnt}, 64'd1);
    cyc(1, 2'b11, 7, 7, 8'h77, 8'h70, 0, 0);
    chk("tie_rotate", {62'd0, bus.gnt}, 64'd2);

    // solo burst: no rotation without a waiter
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 21; i++) begin
      cyc(1, 2'b01, 3'(i % 8), 0, 8'(8'h40 + i), 0, 0, 0);
      chk("solo_gnt", {62'd0, bus.gnt}, 64'd1);
    end
    cyc(1, 2'b00, 0, 0, 0, 0, 1, 1);

    // swap colliding with a beat on row 0
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc(1, 2'b01, 0, 0, 8'h11, 0, 0, 0);
    cyc(1, 2'b01, 0, 0, 8'h11, 0, 1, 0);
    cyc(1, 2'b01, 0, 0, 8'h22, 0, 0, 1);
    chk("coll_front", {56'd0, bus.matdata[7:0]}, 64'h11);
    cyc(1, 2'b00, 0, 0, 0, 0, 1, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 0, 1);
    chk("coll_next", {56'd0, bus.matdata[7:0]}, 64'h22);

    // reset in the middle of an OWN1 burst with a pending swap
    cyc(1, 2'b10, 0, 5, 0, 8'h55, 1, 0);
    cyc(1, 2'b10, 0, 5, 0, 8'h55, 0, 0);
    chk("mid_gnt", {62'd0, bus.gnt}, 64'd2);
    cyc(0, 2'b11, 0, 5, 0, 8'h55, 0, 1);
    chk("mid_rst_gnt", {62'd0, bus.gnt}, 64'd0);
    chk("mid_rst_mat", bus.matdata, 64'd0);
    chk("mid_rst_pend", {63'd0, bus.swap_pending}, 64'd0);
    cyc(1, 2'b11, 0, 5, 0, 8'h55, 0, 0);
    chk("mid_after", {62'd0, bus.gnt}, 64'd1);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom_range(499) != 0), 2'($urandom), 3'($urandom), 3'($urandom),
          8'($urandom), 8'($urandom), ($urandom_range(7) == 0), ($urandom_range(5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
